// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO result registers.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset
//   start  - begin an operation (sampled only while busy=0)
//   op     - 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   A, B   - operands (multiplicand/multiplier or dividend/divisor)
//   hi_we  - MTHI: load hi from wdata while idle
//   lo_we  - MTLO: load lo from wdata while idle
//   wdata  - data for MTHI/MTLO
//   busy   - operation in progress
//   done   - one-cycle pulse when new hi/lo values become visible
//   hi, lo - result registers (product high/low, or remainder/quotient)
//
// Timing: start accepted at edge E, 32 iteration edges E+1..E+32 in RUN,
// FINISH for one cycle, results written and done raised at edge E+33.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q;
    logic        is_div_q;   // op[1]: divide rather than multiply
    logic [63:0] acc_q;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opb_q;      // magnitude of B (multiplicand or divisor)
    logic [31:0] a_q;        // original A, returned as hi on divide by zero
    logic [4:0]  cnt_q;
    logic        neg_q;      // negate product / quotient
    logic        rneg_q;     // negate remainder (follows dividend sign)
    logic        bzero_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Signed ops (MULT, DIV) have op[0]=0; they work on magnitudes.
    logic        is_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rs;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_d;
    logic [63:0] mul_res;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] res_d;

    always_comb begin
        is_signed = ~op[0];
        a_mag     = (is_signed && A[31]) ? (32'd0 - A) : A;
        b_mag     = (is_signed && B[31]) ? (32'd0 - B) : B;

        // Shift-add step: add multiplicand into upper half when the current
        // multiplier LSB is set, then shift the whole 65-bit value right.
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        // Restoring step: shift the next dividend bit into the remainder and
        // keep the subtraction only if it did not go negative.
        div_rs   = {acc_q[63:32], acc_q[31]};
        div_diff = div_rs - {1'b0, opb_q};
        div_next = div_diff[32] ? {div_rs[31:0], acc_q[30:0], 1'b0}
                                : {div_diff[31:0], acc_q[30:0], 1'b1};

        acc_d = is_div_q ? div_next : mul_next;

        mul_res = neg_q ? (64'd0 - acc_q) : acc_q;
        quot    = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem     = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

        if (!is_div_q) begin
            res_d = mul_res;
        end else if (bzero_q) begin
            res_d = {a_q, 32'hFFFF_FFFF};
        end else begin
            res_d = {rem, quot};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            a_q      <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        is_div_q <= op[1];
                        acc_q    <= {32'd0, a_mag};
                        opb_q    <= b_mag;
                        a_q      <= A;
                        cnt_q    <= 5'd0;
                        neg_q    <= is_signed & (A[31] ^ B[31]);
                        rneg_q   <= is_signed & A[31];
                        bzero_q  <= (B == 32'd0);
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FINISH;
                end
                FINISH: begin
                    hi_q    <= res_d[63:32];
                    lo_q    <= res_d[31:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed operations with hand-computed results.
// Stimulus pushes expected {hi,lo} into a queue; a monitor process pops and
// compares on every done pulse and also checks busy length and hi/lo hold.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; optionally register the expected result.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input bit push);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (push) exp_q.push_back(e);
        $display("issue op=%0d A=%h B=%h expect hi=%h lo=%h", o, a, b, e[63:32], e[31:0]);
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic monitor();
        int          busy_len = 0;
        logic        busy_prev = 1'b0;
        logic [31:0] hi_prev = 32'd0;
        logic [31:0] lo_prev = 32'd0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_len = 0;
            end else begin
                if (busy && busy_prev) begin
                    chk("hold_hi", hi, hi_prev);
                    chk("hold_lo", lo, lo_prev);
                end
                if (busy) busy_len++;
                if (done) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", {31'd0, done}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hi", hi, e[63:32]);
                        chk("lo", lo, e[31:0]);
                        chk("busy_cycles", 32'(busy_len), 32'd33);
                        chk("busy_at_done", {31'd0, busy}, 32'd0);
                        $display("done hi=%h lo=%h busy_cycles=%0d", hi, lo, busy_len);
                    end
                    busy_len = 0;
                end
            end
            busy_prev = busy;
            hi_prev   = hi;
            lo_prev   = lo;
        end
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        A     = 32'd0;
        B     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // First edge with rst=0 and start=1 must accept.
        rst = 1'b0;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b1);
        @(negedge clk);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done();

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, {32'h0000_0001, 32'hFFFF_FFFE}, 1'b1);
        wait_done();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        wait_done();

        // MTHI/MTLO in the accepting cycle must be ignored.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_BEEF;
        issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000, {32'h0000_0007, 32'hFFFF_FFFF}, 1'b1);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("we_on_start_hi", hi, 32'hFFFF_FFFF);
        chk("we_on_start_lo", lo, 32'hFFFF_FFFD);
        wait_done();

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b1);
        wait_done();

        // start and MTHI while busy are both ignored.
        d0 = done_seen;
        issue(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
        repeat (8) tick();
        start = 1'b1;
        op    = OP_MULT;
        A     = 32'd5;
        B     = 32'd5;
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        wait_done();

        // Back-to-back: start in the done cycle.
        issue(OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done();
        tick();
        chk("done_pulses", 32'(done_seen - d0), 32'd2);

        // MTHI/MTLO while idle.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAABB_CCDD;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mt_both_hi", hi, 32'hAABB_CCDD);
        chk("mt_both_lo", lo, 32'hAABB_CCDD);
        chk("mt_no_done", {31'd0, done}, 32'd0);
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo_kept", lo, 32'hAABB_CCDD);
        lo_we = 1'b1;
        tick();
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);

        // Reset mid-operation abandons it.
        d0 = done_seen;
        issue(OP_MULT, 32'd3, 32'd4, 64'd0, 1'b0);
        repeat (19) tick();
        rst   = 1'b1;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'h0000_FFFF;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        hi_we = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (40) tick();
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);
        chk("abort_hi_later", hi, 32'd0);

        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1);
        wait_done();
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("total_done", 32'(done_seen), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
